// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared types, port coding and route computation for the mesh router
package noc_pkg;

    localparam int NUM_PORTS = 5;
    localparam int PORT_W    = 3;

    typedef enum logic [1:0] {
        FLIT_BODY   = 2'b00,
        FLIT_HEAD   = 2'b01,
        FLIT_TAIL   = 2'b10,
        FLIT_SINGLE = 2'b11
    } flit_type_e;

    typedef enum logic [PORT_W-1:0] {
        LOCAL = 3'd0,
        NORTH = 3'd1,
        EAST  = 3'd2,
        SOUTH = 3'd3,
        WEST  = 3'd4
    } port_e;

    function automatic logic opens_packet(input logic [1:0] ftype);
        return (flit_type_e'(ftype) == FLIT_HEAD) || (flit_type_e'(ftype) == FLIT_SINGLE);
    endfunction

    function automatic logic closes_packet(input logic [1:0] ftype);
        return (flit_type_e'(ftype) == FLIT_TAIL) || (flit_type_e'(ftype) == FLIT_SINGLE);
    endfunction

    // y grows southward; yx_mode corrects the row before the column
    function automatic port_e route_compute(
        input int   dst_x,
        input int   dst_y,
        input int   own_x,
        input int   own_y,
        input logic yx_mode
    );
        port_e px;
        port_e py;
        px = (dst_x > own_x) ? EAST  : ((dst_x < own_x) ? WEST  : LOCAL);
        py = (dst_y > own_y) ? SOUTH : ((dst_y < own_y) ? NORTH : LOCAL);
        if (yx_mode) begin
            return (py != LOCAL) ? py : px;
        end
        return (px != LOCAL) ? px : py;
    endfunction

endpackage

// File: rtl/noc_input_fifo.sv
// rtl/noc_input_fifo.sv - per-input flit FIFO with wrap-bit pointers
module noc_input_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rdata = mem[rd_ptr[AW-1:0]];
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/wormhole_router.sv
// rtl/wormhole_router.sv - five-port wormhole mesh router with per-output locks and round-robin
module wormhole_router
    import noc_pkg::*;
#(
    parameter int FLIT_SIZE  = 18,
    parameter int FIFO_DEPTH = 4,
    parameter int NOC_LENGTH = 4,
    parameter int NOC_WIDTH  = 4,
    parameter int ROUTER_ID  = 0,
    parameter int ROUTE_MODE = 0
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_PORTS-1:0]                 in_req,
    output logic [NUM_PORTS-1:0]                 in_ack,
    input  logic [NUM_PORTS-1:0][FLIT_SIZE-1:0]  in_data,
    output logic [NUM_PORTS-1:0]                 out_req,
    input  logic [NUM_PORTS-1:0]                 out_ack,
    output logic [NUM_PORTS-1:0][FLIT_SIZE-1:0]  out_data
);

    localparam int X_W   = $clog2(NOC_WIDTH);
    localparam int Y_W   = $clog2(NOC_LENGTH);
    localparam int OWN_X = ROUTER_ID % NOC_WIDTH;
    localparam int OWN_Y = ROUTER_ID / NOC_WIDTH;

    logic                                rdy_q;
    logic [NUM_PORTS-1:0]                fifo_full;
    logic [NUM_PORTS-1:0]                fifo_empty;
    logic [NUM_PORTS-1:0]                fifo_push;
    logic [NUM_PORTS-1:0]                fifo_pop;
    logic [NUM_PORTS-1:0][FLIT_SIZE-1:0] fifo_head;

    logic [NUM_PORTS-1:0]                in_is_head;
    logic [NUM_PORTS-1:0]                in_busy;
    logic [PORT_W-1:0]                   in_route [NUM_PORTS];

    logic [NUM_PORTS-1:0]                lock_valid;
    logic [NUM_PORTS-1:0][PORT_W-1:0]    lock_owner;
    logic [NUM_PORTS-1:0][PORT_W-1:0]    rr_ptr;
    logic [NUM_PORTS-1:0]                grant_valid;
    logic [NUM_PORTS-1:0][PORT_W-1:0]    grant_idx;
    logic [NUM_PORTS-1:0]                move;
    logic [NUM_PORTS-1:0][FLIT_SIZE-1:0] move_data;
    logic [NUM_PORTS-1:0]                oreg_valid;
    logic [NUM_PORTS-1:0][FLIT_SIZE-1:0] oreg_data;

    // rdy_q keeps in_ack low through reset and raises it on the first edge after release
    assign in_ack    = {NUM_PORTS{rdy_q}} & ~fifo_full;
    assign fifo_push = in_req & in_ack;
    assign out_req   = oreg_valid;
    assign out_data  = oreg_data;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_fifo
        noc_input_fifo #(
            .WIDTH (FLIT_SIZE),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst_n (rst),
            .push  (fifo_push[i]),
            .wdata (in_data[i]),
            .pop   (fifo_pop[i]),
            .rdata (fifo_head[i]),
            .full  (fifo_full[i]),
            .empty (fifo_empty[i])
        );
    end

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            in_is_head[i] = !fifo_empty[i] && opens_packet(fifo_head[i][FLIT_SIZE-1 -: 2]);
            in_route[i]   = route_compute(int'(fifo_head[i][X_W-1:0]),
                                          int'(fifo_head[i][X_W+Y_W-1:X_W]),
                                          OWN_X, OWN_Y, ROUTE_MODE == 1);
            in_busy[i]    = 1'b0;
            for (int o = 0; o < NUM_PORTS; o++) begin
                if (lock_valid[o] && lock_owner[o] == PORT_W'(i)) in_busy[i] = 1'b1;
            end
        end
    end

    // Free outputs arbitrate among head flits; locked outputs stream from their owner
    always_comb begin
        int idx;
        idx      = 0;
        fifo_pop = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            grant_valid[o] = 1'b0;
            grant_idx[o]   = '0;
            move[o]        = 1'b0;
            move_data[o]   = '0;
            if (!lock_valid[o]) begin
                for (int k = 1; k <= NUM_PORTS; k++) begin
                    idx = (int'(rr_ptr[o]) + k) % NUM_PORTS;
                    if (!grant_valid[o] && in_is_head[idx] && !in_busy[idx] &&
                        in_route[idx] == PORT_W'(o)) begin
                        grant_valid[o] = 1'b1;
                        grant_idx[o]   = PORT_W'(idx);
                    end
                end
            end else begin
                for (int i = 0; i < NUM_PORTS; i++) begin
                    if (lock_owner[o] == PORT_W'(i) && !fifo_empty[i] &&
                        (!oreg_valid[o] || out_ack[o])) begin
                        move[o]      = 1'b1;
                        move_data[o] = fifo_head[i];
                        fifo_pop[i]  = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdy_q      <= 1'b0;
            lock_valid <= '0;
            lock_owner <= '0;
            rr_ptr     <= {NUM_PORTS{PORT_W'(NUM_PORTS - 1)}};
            oreg_valid <= '0;
            oreg_data  <= '0;
        end else begin
            rdy_q <= 1'b1;
            for (int o = 0; o < NUM_PORTS; o++) begin
                if (!oreg_valid[o] || out_ack[o]) begin
                    oreg_valid[o] <= move[o];
                    if (move[o]) oreg_data[o] <= move_data[o];
                end
                // A closing flit frees the output; the next grant is registered a cycle later
                if (lock_valid[o]) begin
                    if (move[o] && closes_packet(move_data[o][FLIT_SIZE-1 -: 2])) begin
                        lock_valid[o] <= 1'b0;
                    end
                end else if (grant_valid[o]) begin
                    lock_valid[o] <= 1'b1;
                    lock_owner[o] <= grant_idx[o];
                    rr_ptr[o]     <= grant_idx[o];
                end
            end
        end
    end

endmodule

// File: tb/tb_wormhole_router.sv
// tb/tb_wormhole_router.sv - scoreboard bench for wormhole_router in XY and YX modes at node 5
module tb_wormhole_router;

    localparam int FS  = 18;
    localparam int FD  = 4;
    localparam int P_L = 0;
    localparam int P_N = 1;
    localparam int P_E = 2;
    localparam int P_S = 3;
    localparam int P_W = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic [4:0]          in_req;
    logic [4:0]          out_ack;
    logic [4:0][FS-1:0]  in_data;
    logic [4:0]          in_ack0, in_ack1, out_req0, out_req1;
    logic [4:0][FS-1:0]  out_data0, out_data1;

    always #5 clk = ~clk;

    wormhole_router #(.FLIT_SIZE(FS), .FIFO_DEPTH(FD), .NOC_LENGTH(4), .NOC_WIDTH(4),
                      .ROUTER_ID(5), .ROUTE_MODE(0)) dut_xy (
        .clk(clk), .rst(rst), .in_req(in_req), .in_ack(in_ack0), .in_data(in_data),
        .out_req(out_req0), .out_ack(out_ack), .out_data(out_data0));

    wormhole_router #(.FLIT_SIZE(FS), .FIFO_DEPTH(FD), .NOC_LENGTH(4), .NOC_WIDTH(4),
                      .ROUTER_ID(5), .ROUTE_MODE(1)) dut_yx (
        .clk(clk), .rst(rst), .in_req(in_req), .in_ack(in_ack1), .in_data(in_data),
        .out_req(out_req1), .out_ack(out_ack), .out_data(out_data1));

    typedef struct { int dut; int port; logic [FS-1:0] flit; } exp_t;
    typedef struct { int src; int dx; int dy; int exp_xy; int exp_yx; } vec_t;

    exp_t sb[$];
    vec_t vecs[9];
    int   local_times[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   acc_cnt = 0;

    function automatic logic [FS-1:0] pkt_flit(input int n, input int k, input int dx,
                                               input int dy, input int tag);
        logic [1:0] t;
        if (n == 1)          t = 2'b11;
        else if (k == 0)     t = 2'b01;
        else if (k == n - 1) t = 2'b10;
        else                 t = 2'b00;
        return {t, 8'(tag), 4'(k), 2'(dy), 2'(dx)};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic push_exp(input int d, input int o, input logic [FS-1:0] f);
        exp_t e;
        e.dut  = d;
        e.port = o;
        e.flit = f;
        sb.push_back(e);
    endtask

    task automatic sb_pop(input int d, input int o, input logic [FS-1:0] f);
        int idx = -1;
        for (int i = 0; i < sb.size(); i++) begin
            if (idx < 0 && sb[i].dut == d && sb[i].port == o) idx = i;
        end
        n_tests++;
        if (idx < 0) begin
            n_fail++;
            $display("FAIL unexpected_out dut%0d port%0d: got %0h, required no flit", d, o, f);
        end else begin
            if (sb[idx].flit !== f) begin
                n_fail++;
                $display("FAIL out_data dut%0d port%0d: got %0h, required %0h", d, o, f, sb[idx].flit);
            end
            sb.delete(idx);
        end
        if (d == 0 && o == P_L) local_times.push_back(cyc);
    endtask

    always @(negedge clk) begin
        cyc++;
        if (rst === 1'b1) begin
            for (int o = 0; o < 5; o++) begin
                if (out_req0[o] && out_ack[o]) sb_pop(0, o, out_data0[o]);
                if (out_req1[o] && out_ack[o]) sb_pop(1, o, out_data1[o]);
            end
        end
    end

    task automatic drive_packet(input int p, input int n, input int dx, input int dy, input int tag,
                                input int exp0, input int exp1, input bit want_exp);
        int          b;
        logic [FS-1:0] f;
        for (int k = 0; k < n; k++) begin
            f          = pkt_flit(n, k, dx, dy, tag);
            in_req[p]  = 1'b1;
            in_data[p] = f;
            b          = 0;
            @(negedge clk);
            while (!in_ack0[p] && b < 200) begin
                b++;
                @(negedge clk);
            end
            if (!in_ack0[p]) begin
                n_tests++;
                n_fail++;
                $display("FAIL drive_timeout port%0d: in_ack 0, required 1", p);
                in_req[p] = 1'b0;
                return;
            end
            acc_cnt++;
            if (want_exp) begin
                push_exp(0, exp0, f);
                push_exp(1, exp1, f);
            end
            @(posedge clk);
            #1;
        end
        in_req[p] = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int b = 0;
        while (sb.size() != 0 && b < 100) begin
            b++;
            @(negedge clk);
        end
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s: %0d flits outstanding, required 0", name, sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [FS-1:0] f;

        vecs[0] = '{P_L, 3, 2, P_E, P_S};
        vecs[1] = '{P_N, 0, 1, P_W, P_W};
        vecs[2] = '{P_E, 1, 0, P_N, P_N};
        vecs[3] = '{P_S, 1, 3, P_S, P_S};
        vecs[4] = '{P_W, 1, 1, P_L, P_L};
        vecs[5] = '{P_L, 0, 3, P_W, P_S};
        vecs[6] = '{P_S, 2, 0, P_E, P_N};
        vecs[7] = '{P_E, 3, 2, P_E, P_S};
        vecs[8] = '{P_N, 0, 0, P_W, P_N};

        rst     = 1'b0;
        in_req  = '0;
        in_data = '0;
        out_ack = '1;
        repeat (2) @(negedge clk);
        check("rst_in_ack_xy", in_ack0, 0);
        check("rst_in_ack_yx", in_ack1, 0);
        check("rst_out_req_xy", out_req0, 0);
        check("rst_out_req_yx", out_req1, 0);
        check("rst_out_data_xy", out_data0, 0);
        check("rst_out_data_yx", out_data1, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_ack_xy", in_ack0, 5'h1f);
        check("post_rst_ack_yx", in_ack1, 5'h1f);

        // single flit latency: accepted at edge t, visible after edge t+2
        f          = pkt_flit(1, 0, 3, 2, 8'h31);
        in_req[0]  = 1'b1;
        in_data[0] = f;
        @(negedge clk);
        check("lat_accept", in_ack0[0], 1);
        push_exp(0, P_E, f);
        push_exp(1, P_S, f);
        @(posedge clk);
        #1;
        in_req[0] = 1'b0;
        @(negedge clk);
        check("lat_t0", out_req0[P_E], 0);
        @(negedge clk);
        check("lat_t1", out_req0[P_E], 0);
        @(negedge clk);
        check("lat_t2_xy_req", out_req0[P_E], 1);
        check("lat_t2_xy_data", out_data0[P_E], f);
        check("lat_t2_yx_req", out_req1[P_S], 1);
        check("lat_t2_yx_data", out_data1[P_S], f);
        wait_drain("lat_drain");

        for (int v = 0; v < 9; v++) begin
            drive_packet(vecs[v].src, 1, vecs[v].dx, vecs[v].dy, 64 + v,
                         vecs[v].exp_xy, vecs[v].exp_yx, 1'b1);
            wait_drain($sformatf("vec%0d_drain", v));
        end

        // N and W race for LOCAL: N wins, W follows after one bubble
        for (int k = 0; k < 3; k++) begin
            push_exp(0, P_L, pkt_flit(3, k, 1, 1, 8'hA1));
            push_exp(1, P_L, pkt_flit(3, k, 1, 1, 8'hA1));
        end
        for (int k = 0; k < 3; k++) begin
            push_exp(0, P_L, pkt_flit(3, k, 1, 1, 8'hA4));
            push_exp(1, P_L, pkt_flit(3, k, 1, 1, 8'hA4));
        end
        local_times.delete();
        fork
            drive_packet(P_N, 3, 1, 1, 8'hA1, 0, 0, 1'b0);
            drive_packet(P_W, 3, 1, 1, 8'hA4, 0, 0, 1'b0);
        join
        wait_drain("rr_drain");
        check("rr_count", local_times.size(), 6);
        if (local_times.size() == 6) begin
            check("rr_n_stream", local_times[2] - local_times[0], 2);
            check("rr_bubble", local_times[3] - local_times[2], 2);
            check("rr_w_stream", local_times[5] - local_times[3], 2);
        end

        // EAST stalled: FIFO plus output register fill, then all six drain in order
        out_ack[P_E] = 1'b0;
        acc_cnt      = 0;
        for (int k = 0; k < 6; k++) begin
            push_exp(0, P_E, pkt_flit(6, k, 3, 1, 8'hB6));
            push_exp(1, P_E, pkt_flit(6, k, 3, 1, 8'hB6));
        end
        fork
            drive_packet(P_L, 6, 3, 1, 8'hB6, 0, 0, 1'b0);
            begin
                repeat (10) @(negedge clk);
                check("bp_accepted", acc_cnt, FD + 1);
                check("bp_in_ack", in_ack0[P_L], 0);
                check("bp_out_req", out_req0[P_E], 1);
                check("bp_out_head", out_data0[P_E], pkt_flit(6, 0, 3, 1, 8'hB6));
                @(posedge clk);
                #1;
                out_ack[P_E] = 1'b1;
            end
        join
        wait_drain("bp_drain");

        // reset in the middle of a packet held on EAST
        out_ack[P_E] = 1'b0;
        in_req[0]    = 1'b1;
        in_data[0]   = pkt_flit(4, 0, 3, 1, 8'hC4);
        @(negedge clk);
        @(posedge clk);
        #1;
        in_data[0] = pkt_flit(4, 1, 3, 1, 8'hC4);
        @(negedge clk);
        @(posedge clk);
        #1;
        in_req[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mid_pre_req", out_req0[P_E], 1);
        #2;
        rst = 1'b0;
        #1;
        check("rst_mid_req_xy", out_req0, 0);
        check("rst_mid_req_yx", out_req1, 0);
        check("rst_mid_data_xy", out_data0, 0);
        check("rst_mid_data_yx", out_data1, 0);
        check("rst_mid_ack_xy", in_ack0, 0);
        check("rst_mid_ack_yx", in_ack1, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_rel_ack_xy", in_ack0, 5'h1f);
        check("rst_mid_rel_ack_yx", in_ack1, 5'h1f);
        out_ack[P_E] = 1'b1;
        drive_packet(P_S, 2, 3, 1, 8'hC7, P_E, P_E, 1'b1);
        wait_drain("post_rst_drain");

        check("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
